// File: rtl/card_judge.sv
// Two-player card scoring judge: accepts drawn cards in PLAY, accumulates
// scores with a same-colour bonus, and declares a winner on target or card limit.
module card_judge #(
  parameter logic [7:0] TARGET    = 8'd21,
  parameter logic [3:0] MAX_CARDS = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       card_valid,
  input  logic       whose,
  input  logic [1:0] color,
  input  logic [2:0] number,
  output logic       card_ready,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic [3:0] cnt1,
  output logic [3:0] cnt2,
  output logic [1:0] winner,
  output logic       game_over
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_CHECK, S_DONE} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_score1, r_score2;
  logic [3:0] r_cnt1, r_cnt2;
  logic [1:0] r_last1, r_last2;
  logic       r_who;
  logic [1:0] r_winner;

  logic [3:0] w_own_cnt;
  logic [1:0] w_own_last;
  logic [7:0] w_own_score;
  logic       w_accept;
  logic [3:0] w_add;
  logic [8:0] w_sum;
  logic [7:0] w_new_score;
  logic [7:0] w_chk_score;
  logic       w_win_hit;
  logic       w_limit;
  logic       w_finish;
  logic [1:0] w_win_code;

  assign w_own_cnt   = whose ? r_cnt2   : r_cnt1;
  assign w_own_last  = whose ? r_last2  : r_last1;
  assign w_own_score = whose ? r_score2 : r_score1;

  // new_game takes priority, so a card in the same cycle is dropped
  assign w_accept = card_valid && !new_game && (r_state == S_PLAY) &&
                    (color != 2'b00) && (number >= 3'd1) && (number <= 3'd5) &&
                    (w_own_cnt != MAX_CARDS);

  // last colour is 00 at game start, so the first card never matches
  assign w_add       = (color == w_own_last) ? {number, 1'b0} : {1'b0, number};
  assign w_sum       = {1'b0, w_own_score} + {5'd0, w_add};
  assign w_new_score = w_sum[8] ? 8'hFF : w_sum[7:0];

  assign w_chk_score = r_who ? r_score2 : r_score1;
  assign w_win_hit   = (w_chk_score >= TARGET);
  assign w_limit     = (r_cnt1 == MAX_CARDS) && (r_cnt2 == MAX_CARDS);
  assign w_finish    = w_win_hit || w_limit;

  always_comb begin
    w_win_code = 2'b11;
    if (w_win_hit)                 w_win_code = r_who ? 2'b10 : 2'b01;
    else if (r_score1 > r_score2)  w_win_code = 2'b01;
    else if (r_score2 > r_score1)  w_win_code = 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (new_game) begin
      w_next = S_PLAY;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_PLAY:  if (w_accept) w_next = S_CHECK;
        S_CHECK: w_next = w_finish ? S_DONE : S_PLAY;
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score1 <= 8'd0;
      r_score2 <= 8'd0;
      r_cnt1   <= 4'd0;
      r_cnt2   <= 4'd0;
      r_last1  <= 2'b00;
      r_last2  <= 2'b00;
      r_who    <= 1'b0;
      r_winner <= 2'b00;
    end else if (new_game) begin
      r_score1 <= 8'd0;
      r_score2 <= 8'd0;
      r_cnt1   <= 4'd0;
      r_cnt2   <= 4'd0;
      r_last1  <= 2'b00;
      r_last2  <= 2'b00;
      r_who    <= 1'b0;
      r_winner <= 2'b00;
    end else begin
      if (w_accept) begin
        r_who <= whose;
        if (whose) begin
          r_score2 <= w_new_score;
          r_cnt2   <= r_cnt2 + 4'd1;
          r_last2  <= color;
        end else begin
          r_score1 <= w_new_score;
          r_cnt1   <= r_cnt1 + 4'd1;
          r_last1  <= color;
        end
      end
      if ((r_state == S_CHECK) && w_finish) r_winner <= w_win_code;
    end
  end

  assign card_ready = (r_state == S_PLAY);
  assign game_over  = (r_state == S_DONE);
  assign score1     = r_score1;
  assign score2     = r_score2;
  assign cnt1       = r_cnt1;
  assign cnt2       = r_cnt2;
  assign winner     = r_winner;

endmodule

// File: tb/tb_card_judge.sv
// Bench for card_judge: two instances (default and MAX_CARDS=2) driven in
// parallel, checked every cycle against a rule-level game model.
module tb_card_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_game, card_valid, whose;
  logic [1:0] color;
  logic [2:0] number;

  logic       o_ready [2];
  logic [7:0] o_s1 [2];
  logic [7:0] o_s2 [2];
  logic [3:0] o_c1 [2];
  logic [3:0] o_c2 [2];
  logic [1:0] o_win [2];
  logic       o_over [2];

  card_judge u_dut0 (
    .clk(clk), .rst(rst), .new_game(new_game), .card_valid(card_valid),
    .whose(whose), .color(color), .number(number),
    .card_ready(o_ready[0]), .score1(o_s1[0]), .score2(o_s2[0]),
    .cnt1(o_c1[0]), .cnt2(o_c2[0]), .winner(o_win[0]), .game_over(o_over[0])
  );

  card_judge #(.TARGET(8'd21), .MAX_CARDS(4'd2)) u_dut1 (
    .clk(clk), .rst(rst), .new_game(new_game), .card_valid(card_valid),
    .whose(whose), .color(color), .number(number),
    .card_ready(o_ready[1]), .score1(o_s1[1]), .score2(o_s2[1]),
    .cnt1(o_c1[1]), .cnt2(o_c2[1]), .winner(o_win[1]), .game_over(o_over[1])
  );

  always #5 clk = ~clk;

  // model: phase 0 idle, 1 play, 2 judging, 3 over
  int m_max [2] = '{8, 2};
  int m_phase [2];
  int m_score [2][2];
  int m_cnt [2][2];
  int m_last [2][2];
  int m_lw [2];
  int m_win [2];

  int n_checks = 0;
  int n_pass = 0;

  task automatic model_clear(input int k, input int phase);
    m_phase[k] = phase;
    m_lw[k]    = 0;
    m_win[k]   = 0;
    for (int p = 0; p < 2; p++) begin
      m_score[k][p] = 0;
      m_cnt[k][p]   = 0;
      m_last[k][p]  = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit ng, input bit cv,
                            input int w, input int c, input int n);
    int add;
    if (ng) begin
      model_clear(k, 1);
      return;
    end
    if (m_phase[k] == 1) begin
      if (cv && c != 0 && n >= 1 && n <= 5 && m_cnt[k][w] != m_max[k]) begin
        add = (c == m_last[k][w]) ? 2 * n : n;
        m_score[k][w] = (m_score[k][w] + add > 255) ? 255 : m_score[k][w] + add;
        m_cnt[k][w]  += 1;
        m_last[k][w]  = c;
        m_lw[k]       = w;
        m_phase[k]    = 2;
      end
    end else if (m_phase[k] == 2) begin
      if (m_score[k][m_lw[k]] >= 21) begin
        m_win[k]   = m_lw[k] + 1;
        m_phase[k] = 3;
      end else if (m_cnt[k][0] == m_max[k] && m_cnt[k][1] == m_max[k]) begin
        if (m_score[k][0] > m_score[k][1])      m_win[k] = 1;
        else if (m_score[k][1] > m_score[k][0]) m_win[k] = 2;
        else                                    m_win[k] = 3;
        m_phase[k] = 3;
      end else begin
        m_phase[k] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string where);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s/i%0d/score1", where, k), 32'(o_s1[k]), 32'(m_score[k][0]));
      chk($sformatf("%s/i%0d/score2", where, k), 32'(o_s2[k]), 32'(m_score[k][1]));
      chk($sformatf("%s/i%0d/cnt1", where, k), 32'(o_c1[k]), 32'(m_cnt[k][0]));
      chk($sformatf("%s/i%0d/cnt2", where, k), 32'(o_c2[k]), 32'(m_cnt[k][1]));
      chk($sformatf("%s/i%0d/winner", where, k), 32'(o_win[k]), 32'(m_win[k]));
      chk($sformatf("%s/i%0d/game_over", where, k), 32'(o_over[k]), 32'(m_phase[k] == 3));
      chk($sformatf("%s/i%0d/card_ready", where, k), 32'(o_ready[k]), 32'(m_phase[k] == 1));
    end
  endtask

  task automatic step(input string where, input bit ng, input bit cv,
                      input bit w, input int c, input int n);
    new_game   = ng;
    card_valid = cv;
    whose      = w;
    color      = 2'(c);
    number     = 3'(n);
    for (int k = 0; k < 2; k++) model_edge(k, ng, cv, int'(w), c, n);
    @(posedge clk);
    #1;
    new_game   = 1'b0;
    card_valid = 1'b0;
    chk_all(where);
  endtask

  task automatic idle(input string where);
    step(where, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; new_game = 1'b0; card_valid = 1'b0;
    whose = 1'b0; color = 2'b00; number = 3'd0;
    for (int k = 0; k < 2; k++) model_clear(k, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    #2 rst = 1'b0;

    step("idle_card", 1'b0, 1'b1, 1'b0, 1, 3);
    step("new_game", 1'b1, 1'b0, 1'b0, 0, 0);

    step("p1_c1", 1'b0, 1'b1, 1'b0, 1, 3);
    idle("p1_c1_chk");
    step("p1_c2", 1'b0, 1'b1, 1'b0, 2, 4);
    idle("p1_c2_chk");

    step("col00", 1'b0, 1'b1, 1'b1, 0, 4);
    step("num6", 1'b0, 1'b1, 1'b1, 3, 6);
    step("num0", 1'b0, 1'b1, 1'b1, 3, 0);

    step("p2_c1", 1'b0, 1'b1, 1'b1, 3, 5);
    step("in_check", 1'b0, 1'b1, 1'b1, 3, 5);
    step("p2_c2", 1'b0, 1'b1, 1'b1, 3, 5);
    idle("p2_c2_chk");
    step("p2_c3", 1'b0, 1'b1, 1'b1, 3, 5);
    idle("p2_c3_chk");
    step("done_card", 1'b0, 1'b1, 1'b0, 1, 2);
    idle("done_hold");

    step("tie_ng", 1'b1, 1'b0, 1'b0, 0, 0);
    step("tie_a", 1'b0, 1'b1, 1'b0, 1, 1);
    idle("tie_a_chk");
    step("tie_b", 1'b0, 1'b1, 1'b1, 2, 1);
    idle("tie_b_chk");
    step("tie_c", 1'b0, 1'b1, 1'b0, 2, 2);
    idle("tie_c_chk");
    step("tie_d", 1'b0, 1'b1, 1'b1, 1, 2);
    idle("tie_d_chk");
    step("tie_after", 1'b0, 1'b1, 1'b0, 3, 5);
    idle("tie_after2");

    step("ng_and_card", 1'b1, 1'b1, 1'b0, 1, 5);
    step("play_card", 1'b0, 1'b1, 1'b0, 1, 4);
    idle("play_card_chk");

    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) model_clear(k, 0);
    chk_all("async_rst");
    #2 rst = 1'b0;
    step("post_rst_card", 1'b0, 1'b1, 1'b1, 2, 3);
    step("post_rst_ng", 1'b1, 1'b0, 1'b0, 0, 0);
    step("post_rst_play", 1'b0, 1'b1, 1'b1, 2, 3);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
